// File: rtl/pwm_clk_pkg.sv
// Shared types and helpers for the PWM / clock divider bank.
package pwm_clk_pkg;

  localparam int unsigned DIV_W_DEF = 12;

  typedef logic [DIV_W_DEF-1:0] div_t;

  typedef struct packed {
    div_t div;
    div_t duty;
  } ch_cfg_t;

  // Length of the high phase of the divided clock; odd ratios get the extra cycle.
  function automatic int unsigned half_hi(input int unsigned div);
    return (div + 1) >> 1;
  endfunction

endpackage

// File: rtl/pwm_clk_channel.sv
// One divider/PWM channel: counter, shadow and active ratio/duty, registered outputs.
// Optional complementary output with dead time when PWM_COMPL_EN is defined.
module pwm_clk_channel
  import pwm_clk_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DEF_DIV  = 6,
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_we_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [DIV_W-1:0] cfg_duty_i,
  input  logic             en_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             pwm_o,
`ifdef PWM_COMPL_EN
  output logic             pwm_n_o,
`endif
  output logic             stb_o
);

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d, duty_sh_q, duty_sh_d;
  logic [DIV_W-1:0] div_act_q, div_act_d, duty_act_q, duty_act_d;
  logic             clk_q, clk_d, pwm_q, pwm_d, stb_q, stb_d;
  logic             running, wrap, load, raw_pwm;
  logic [DIV_W-1:0] half;

`ifdef PWM_COMPL_EN
  // hist_q[k] holds the undelayed PWM level from k+1 cycles ago; DEAD_CYC must be >= 1.
  logic [DEAD_CYC-1:0] hist_q, hist_d;
  logic                pwm_n_q, pwm_n_d;
`else
  logic unused_dead_cyc;
  assign unused_dead_cyc = ^DEAD_CYC;
`endif

  assign half = DIV_W'(half_hi(32'(div_act_q)));

  // Next-state: counter sequencing, shadow/active transfer and output levels.
  always_comb begin
    running    = en_i && (div_act_q != '0);
    wrap       = running && (cnt_q == div_act_q - DIV_W'(1));
    // Active values only change at a period boundary, on sync or while idle.
    load       = wrap || sync_i || !en_i;
    raw_pwm    = running && (cnt_q < duty_act_q);
    cnt_d      = (!running || sync_i || wrap) ? '0 : cnt_q + DIV_W'(1);
    div_sh_d   = cfg_we_i ? cfg_div_i : div_sh_q;
    duty_sh_d  = cfg_we_i ? cfg_duty_i : duty_sh_q;
    div_act_d  = load ? div_sh_q : div_act_q;
    duty_act_d = load ? duty_sh_q : duty_act_q;
    clk_d      = running && (cnt_q < half);
    stb_d      = running && (cnt_q == '0);
`ifdef PWM_COMPL_EN
    hist_d  = (hist_q << 1) | DEAD_CYC'(raw_pwm);
    // Either side only goes high once the raw level has been stable for DEAD_CYC cycles.
    pwm_d   = raw_pwm && hist_q[DEAD_CYC-1];
    pwm_n_d = running && !raw_pwm && !hist_q[DEAD_CYC-1];
`else
    pwm_d   = raw_pwm;
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      div_sh_q   <= DefDiv;
      duty_sh_q  <= '0;
      div_act_q  <= DefDiv;
      duty_act_q <= '0;
      clk_q      <= 1'b0;
      pwm_q      <= 1'b0;
      stb_q      <= 1'b0;
`ifdef PWM_COMPL_EN
      hist_q     <= '0;
      pwm_n_q    <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      div_sh_q   <= div_sh_d;
      duty_sh_q  <= duty_sh_d;
      div_act_q  <= div_act_d;
      duty_act_q <= duty_act_d;
      clk_q      <= clk_d;
      pwm_q      <= pwm_d;
      stb_q      <= stb_d;
`ifdef PWM_COMPL_EN
      hist_q     <= hist_d;
      pwm_n_q    <= pwm_n_d;
`endif
    end
  end

  assign clk_o = clk_q;
  assign pwm_o = pwm_q;
  assign stb_o = stb_q;
`ifdef PWM_COMPL_EN
  assign pwm_n_o = pwm_n_q;
`endif

endmodule

// File: rtl/pwm_clk_div_bank.sv
// Bank of NCH independent clock divider / PWM channels with double-buffered config.
// Define PWM_COMPL_EN to add the pwm_n_out complementary outputs with dead time.
module pwm_clk_div_bank
  import pwm_clk_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DEF_DIV  = 6,
  parameter int unsigned DEAD_CYC = 2,
  localparam int unsigned ChW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [ChW-1:0]   cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_duty,
  input  logic [NCH-1:0]   ch_en,
  input  logic             sync,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   pwm_out,
`ifdef PWM_COMPL_EN
  output logic [NCH-1:0]   pwm_n_out,
`endif
  output logic [NCH-1:0]   period_stb
);

  logic [NCH-1:0] ch_we;

  // Channel select; an index beyond NCH matches nothing and the write is dropped.
  always_comb begin
    ch_we = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_we[i] = cfg_we && (32'(cfg_ch) == i);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_clk_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV),
      .DEAD_CYC(DEAD_CYC)
    ) u_ch (
      .clk_i     (clk_in),
      .rst_ni    (rst),
      .cfg_we_i  (ch_we[i]),
      .cfg_div_i (cfg_div),
      .cfg_duty_i(cfg_duty),
      .en_i      (ch_en[i]),
      .sync_i    (sync),
      .clk_o     (clk_out[i]),
      .pwm_o     (pwm_out[i]),
`ifdef PWM_COMPL_EN
      .pwm_n_o   (pwm_n_out[i]),
`endif
      .stb_o     (period_stb[i])
    );
  end

endmodule

// File: tb/tb_pwm_clk_div_bank.sv
// Self-checking bench for pwm_clk_div_bank: per-cycle model compare plus directed checks.
module tb_pwm_clk_div_bank;

  localparam int NCH     = 4;
  localparam int DIV_W   = 12;
  localparam int DEF_DIV = 6;
  localparam int DEAD    = 2;
`ifdef PWM_COMPL_EN
  localparam int PwmLoss = DEAD;
`else
  localparam int PwmLoss = 0;
`endif

  logic             clk_in;
  logic             rst, cfg_we, sync;
  logic [1:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div, cfg_duty;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   clk_out, pwm_out, period_stb;
`ifdef PWM_COMPL_EN
  logic [NCH-1:0]   pwm_n_out;
`endif

  pwm_clk_div_bank #(
    .NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .DEAD_CYC(DEAD)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_duty  (cfg_duty),
    .ch_en     (ch_en),
    .sync      (sync),
    .clk_out   (clk_out),
    .pwm_out   (pwm_out),
`ifdef PWM_COMPL_EN
    .pwm_n_out (pwm_n_out),
`endif
    .period_stb(period_stb)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Model: each channel is a position inside a period whose ratio/duty were latched at its
  // start; the outputs seen after a clock edge describe the position held before that edge.
  int m_pos[NCH], m_div[NCH], m_duty[NCH], m_new_div[NCH], m_new_duty[NCH];
  bit [NCH-1:0] exp_clk = '0, exp_pwm = '0, exp_stb = '0;
  bit m_on, m_last, m_take;
  int m_next;

  always @(posedge clk_in) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst) begin
        m_pos[c] = 0; m_div[c] = DEF_DIV; m_duty[c] = 0;
        m_new_div[c] = DEF_DIV; m_new_duty[c] = 0;
        exp_clk[c] = 0; exp_pwm[c] = 0; exp_stb[c] = 0;
      end else begin
        m_on = ch_en[c] && (m_div[c] > 0);
        exp_clk[c] = m_on && (m_pos[c] < (m_div[c] + 1) / 2);
        exp_pwm[c] = m_on && (m_pos[c] < m_duty[c]);
        exp_stb[c] = m_on && (m_pos[c] == 0);
        m_last = m_on && (m_pos[c] == m_div[c] - 1);
        m_take = m_last || sync || !ch_en[c];
        m_next = (m_on && !sync && !m_last) ? m_pos[c] + 1 : 0;
        if (m_take) begin
          m_div[c] = m_new_div[c];
          m_duty[c] = m_new_duty[c];
        end
        if (cfg_we && int'(cfg_ch) == c) begin
          m_new_div[c] = int'(cfg_div);
          m_new_duty[c] = int'(cfg_duty);
        end
        m_pos[c] = m_next;
      end
    end
  end

  always @(negedge clk_in) begin
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("clk_out[%0d]", c), int'(clk_out[c]), int'(exp_clk[c]));
      check($sformatf("period_stb[%0d]", c), int'(period_stb[c]), int'(exp_stb[c]));
`ifdef PWM_COMPL_EN
      check($sformatf("overlap[%0d]", c), int'(pwm_out[c] & pwm_n_out[c]), 0);
`else
      check($sformatf("pwm_out[%0d]", c), int'(pwm_out[c]), int'(exp_pwm[c]));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int hc[NCH], hp[NCH], hs[NCH];

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic cfg_write(input int ch, input int dv, input int dt);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 12'(dv); cfg_duty = 12'(dt);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_stb(input int c, input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (period_stb[c]) begin
        got = 1;
        break;
      end
    end
    check(name, int'(got), 1);
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < NCH; c++) begin
      hc[c] = 0; hp[c] = 0; hs[c] = 0;
    end
    repeat (n) begin
      for (int c = 0; c < NCH; c++) begin
        hc[c] += int'(clk_out[c]); hp[c] += int'(pwm_out[c]); hs[c] += int'(period_stb[c]);
      end
      tick();
    end
  endtask

  logic [6:0] coll_pat;
`ifdef PWM_COMPL_EN
  bit p_s[30], n_s[30];
  int f_idx, r_idx;
`endif

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_duty = '0;
    ch_en = '0; sync = 1'b0;

    // Reset state and default ratio.
    repeat (3) tick();
    check("reset_outputs", int'({clk_out, pwm_out, period_stb}), 0);
    rst = 1'b1; ch_en = 4'b0001;
    wait_stb(0, "t1_first_stb");
    measure(6);
    check("t1_clk_high", hc[0], 3);
    check("t1_pwm_high", hp[0], 0);
    check("t1_stb_count", hs[0], 1);
    check("t1_period6", int'(period_stb[0]), 1);

    // Odd ratio 5, duty 2.
    cfg_write(0, 5, 2);
    wait_stb(0, "t2_first_stb");
    measure(5);
    check("t2_clk_high", hc[0], 3);
    check("t2_pwm_high", hp[0], 2 - PwmLoss);
    check("t2_stb_count", hs[0], 1);
    check("t2_period5", int'(period_stb[0]), 1);

    // Glitch-free update mid-period on channel 1.
    cfg_write(1, 10, 4);
    tick();
    ch_en = 4'b0011;
    wait_stb(1, "t3_first_stb");
    hc[1] = 0; hp[1] = 0;
    for (int i = 0; i < 10; i++) begin
      hc[1] += int'(clk_out[1]); hp[1] += int'(pwm_out[1]);
      if (i == 2) begin
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 12'd8; cfg_duty = 12'd6;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
    end
    cfg_we = 1'b0;
    check("t3_old_clk_high", hc[1], 5);
    check("t3_old_pwm_high", hp[1], 4 - PwmLoss);
    check("t3_new_period_stb", int'(period_stb[1]), 1);
    measure(8);
    check("t3_new_clk_high", hc[1], 4);
    check("t3_new_pwm_high", hp[1], 6 - PwmLoss);
    check("t3_new_stb_count", hs[1], 1);
    check("t3_period8", int'(period_stb[1]), 1);

    // Boundaries, one per channel.
    ch_en = '0;
    cfg_write(0, 0, 0);
    cfg_write(1, 1, 1);
    cfg_write(2, 12, 12);
    cfg_write(3, 7, 0);
    tick();
    ch_en = 4'hF;
    repeat (4) tick();
    measure(24);
    check("t4_div0_clk", hc[0], 0);
    check("t4_div0_pwm", hp[0], 0);
    check("t4_div0_stb", hs[0], 0);
    check("t4_div1_clk", hc[1], 24);
    check("t4_div1_pwm", hp[1], 24);
    check("t4_div1_stb", hs[1], 24);
    check("t4_full_duty_pwm", hp[2], 24);
    check("t4_div12_clk", hc[2], 12);
    check("t4_div12_stb", hs[2], 2);
    check("t4_zero_duty_pwm", hp[3], 0);

    // Sync aligns channels at random phases.
    ch_en = '0;
    cfg_write(0, 4, 1);
    cfg_write(1, 6, 2);
    cfg_write(2, 8, 3);
    tick();
    ch_en[0] = 1'b1;
    repeat ($urandom_range(1, 5)) tick();
    ch_en[1] = 1'b1;
    repeat ($urandom_range(1, 5)) tick();
    ch_en[2] = 1'b1; ch_en[3] = 1'b1;
    repeat ($urandom_range(3, 9)) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    check("t5_sync_aligned", int'(period_stb), 15);
    repeat (24) tick();
    check("t5_lcm24", int'(period_stb), 7);

    // Write on the wrap cycle of ch0: applies one period later.
    tick(); tick();
    cfg_write(0, 2, 1);
    tick();
    coll_pat = 7'b1010001;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("t5_collision_off%0d", k + 4), int'(period_stb[0]), int'(coll_pat[k]));
      if (k < 6) tick();
    end

    // Reset mid-period discards a pending shadow write.
    cfg_write(1, 3, 3);
    rst = 1'b0;
    tick();
    check("rst_mid_outputs", int'({clk_out, pwm_out, period_stb}), 0);
    rst = 1'b1; ch_en = 4'b0010;
    wait_stb(1, "rst_first_stb");
    measure(12);
    check("rst_clk_high", hc[1], 6);
    check("rst_pwm_high", hp[1], 0);
    check("rst_stb_count", hs[1], 2);

`ifdef PWM_COMPL_EN
    // Dead-time gaps around both edges of pwm_out.
    ch_en = '0;
    cfg_write(0, 10, 5);
    tick();
    ch_en = 4'b0001;
    repeat (12) tick();
    for (int i = 0; i < 30; i++) begin
      p_s[i] = pwm_out[0]; n_s[i] = pwm_n_out[0];
      tick();
    end
    f_idx = -1; r_idx = -1;
    for (int i = 1; i < 28; i++) begin
      if (f_idx < 0 && p_s[i-1] && !p_s[i]) f_idx = i;
      if (r_idx < 0 && n_s[i-1] && !n_s[i]) r_idx = i;
    end
    check("compl_fall_found", int'(f_idx >= 0), 1);
    check("compl_nfall_found", int'(r_idx >= 0), 1);
    if (f_idx >= 0)
      check("compl_gap_after_fall", int'({n_s[f_idx], n_s[f_idx+1], n_s[f_idx+2]}), 1);
    if (r_idx >= 0)
      check("compl_gap_after_nfall", int'({p_s[r_idx], p_s[r_idx+1], p_s[r_idx+2]}), 1);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("compl_rst", int'({pwm_out[0], pwm_n_out[0]}), 0);
    rst = 1'b1;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
